// File: rtl/draw_arbiter.sv
// Draw-job arbiter: round-robin grant among NREQ square requesters; each job erases the
// requester's previously drawn square (in BG_COL) before commanding the new one.
module draw_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter logic [2:0]  BG_COL = 3'b000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [10*NREQ-1:0]   x_in,
  input  logic [10*NREQ-1:0]   y_in,
  input  logic [10*NREQ-1:0]   size_in,
  input  logic [3*NREQ-1:0]    col_in,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic                 eng_go,
  output logic [9:0]           eng_x,
  output logic [9:0]           eng_y,
  output logic [9:0]           eng_size,
  output logic [2:0]           eng_col,
  input  logic                 eng_done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_GO,
    ERASE_WAIT,
    DRAW_GO,
    DRAW_WAIT,
    ACK
  } state_t;

  state_t state, state_nxt;

  logic [9:0] rx [NREQ];
  logic [9:0] ry [NREQ];
  logic [9:0] rs [NREQ];
  logic [2:0] rc [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign rx[i] = x_in[10*i +: 10];
    assign ry[i] = y_in[10*i +: 10];
    assign rs[i] = size_in[10*i +: 10];
    assign rc[i] = col_in[3*i +: 3];
  end

  logic [IW-1:0] ptr, gnt, gnt_q;
  logic          gnt_any;
  logic [9:0]    job_x, job_y, job_size;
  logic [2:0]    job_col;
  logic [9:0]    last_x    [NREQ];
  logic [9:0]    last_y    [NREQ];
  logic [9:0]    last_size [NREQ];
  logic [NREQ-1:0] last_valid;

  // First pending requester at or after ptr, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_any && req[IW'((32'(ptr) + k) % NREQ)]) begin
        gnt_any = 1'b1;
        gnt     = IW'((32'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (gnt_any) begin
          if (last_valid[gnt])   state_nxt = ERASE_GO;
          else if (rs[gnt] == '0) state_nxt = ACK;
          else                   state_nxt = DRAW_GO;
        end
      ERASE_GO:   state_nxt = ERASE_WAIT;
      ERASE_WAIT: if (eng_done) state_nxt = (job_size == '0) ? ACK : DRAW_GO;
      DRAW_GO:    state_nxt = DRAW_WAIT;
      DRAW_WAIT:  if (eng_done) state_nxt = ACK;
      ACK:        state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  assign busy   = (state != IDLE);
  assign eng_go = (state == ERASE_GO) || (state == DRAW_GO);

  always_comb begin
    ack = '0;
    if (state == ACK) ack[gnt_q] = 1'b1;
  end

  // The engine command is loaded on the edge entering a GO state so it is already
  // stable when eng_go rises and holds until the engine reports done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr        <= '0;
      gnt_q      <= '0;
      job_x      <= '0;
      job_y      <= '0;
      job_size   <= '0;
      job_col    <= '0;
      last_valid <= '0;
      eng_x      <= '0;
      eng_y      <= '0;
      eng_size   <= '0;
      eng_col    <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        last_x[i]    <= '0;
        last_y[i]    <= '0;
        last_size[i] <= '0;
      end
    end else begin
      if (state == IDLE && gnt_any) begin
        gnt_q    <= gnt;
        job_x    <= rx[gnt];
        job_y    <= ry[gnt];
        job_size <= rs[gnt];
        job_col  <= rc[gnt];
        if (last_valid[gnt]) begin
          eng_x    <= last_x[gnt];
          eng_y    <= last_y[gnt];
          eng_size <= last_size[gnt];
          eng_col  <= BG_COL;
        end else begin
          eng_x    <= rx[gnt];
          eng_y    <= ry[gnt];
          eng_size <= rs[gnt];
          eng_col  <= rc[gnt];
        end
      end
      if (state == ERASE_WAIT && eng_done) begin
        eng_x    <= job_x;
        eng_y    <= job_y;
        eng_size <= job_size;
        eng_col  <= job_col;
      end
      if (state == ACK) begin
        last_x[gnt_q]     <= job_x;
        last_y[gnt_q]     <= job_y;
        last_size[gnt_q]  <= job_size;
        last_valid[gnt_q] <= (job_size != '0);
        ptr               <= IW'((32'(gnt_q) + 32'd1) % NREQ);
      end
    end
  end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters (0 = ball, 1 = paddle, 2 = brick clear).
REQ-002 SHALL have parameter BG_COL, default 3'b000, the background colour used for erase passes.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester draw request, level, held until matching ack.
REQ-006 SHALL have port x_in  input  10*NREQ  requester i top-left x at bits [10i+9:10i].
REQ-007 SHALL have port y_in  input  10*NREQ  requester i top-left y, same packing.
REQ-008 SHALL have port size_in  input  10*NREQ  requester i square side length, same packing.
REQ-009 SHALL have port col_in  input  3*NREQ  requester i draw colour at bits [3i+2:3i].
REQ-010 SHALL have port ack  output  NREQ  one-cycle pulse: requester i job complete.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port eng_go  output  1  one-cycle start pulse to the square-draw engine.
REQ-013 SHALL have port eng_x, eng_y, eng_size  output  10 each  engine command; registered, stable from eng_go until eng_done.
REQ-014 SHALL have port eng_col  output  3  engine pixel colour; registered, same stability.
REQ-015 SHALL have port eng_done  input  1  one-cycle pulse from engine: square finished.

Function
REQ-016 SHALL implement states IDLE, ERASE_GO, ERASE_WAIT, DRAW_GO, DRAW_WAIT, ACK.
REQ-017 SHALL, in IDLE with any req bit high, grant g = first set bit searching from round-robin pointer ptr upward with wrap-around, latch x/y/size/col of g, and move to ERASE_GO if last_valid[g] else DRAW_GO.
REQ-018 SHALL stay in IDLE while req == 0; a req dropped before grant is never served and produces no ack.
REQ-019 SHALL, in ERASE_GO, drive eng_go=1 for exactly one cycle with eng_x/eng_y/eng_size = stored last_x[g]/last_y[g]/last_size[g], eng_col=BG_COL, then enter ERASE_WAIT.
REQ-020 SHALL, in DRAW_GO, drive eng_go=1 for one cycle with the latched new job and col, then enter DRAW_WAIT; if latched size == 0, skip DRAW_GO/DRAW_WAIT (no eng_go) and go directly to ACK.
REQ-021 SHALL leave ERASE_WAIT for DRAW_GO (or ACK when size==0) and DRAW_WAIT for ACK only on eng_done=1; eng_done in any other state SHALL be ignored.
REQ-022 SHALL, in ACK, pulse ack[g] for one cycle, store last_x/last_y/last_size[g] = latched job, set last_valid[g] = (size != 0), set ptr = (g+1) mod NREQ, return to IDLE.
REQ-023 SHALL sample requester inputs only at the grant edge; changes during service SHALL not affect the active job.
REQ-024 SHALL take at most one job at a time; minimum latency req-high-in-IDLE to eng_go = 1 cycle; a requester re-asserting req immediately after ack is granted only after other pending requesters (fairness).
REQ-025 SHALL not perform range/clipping checks; coordinate arithmetic is the engine's concern; all coordinate registers are 10-bit unsigned.

Reset
REQ-026 SHALL, on resetn=0 at a clock edge, regardless of state, go to IDLE, set ptr=0, last_valid=0, all last_* = 0, and hold ack=0, eng_go=0, busy=0, eng_x/eng_y/eng_size=0, eng_col=0 while resetn=0.
REQ-027 SHALL, after reset mid-job, discard the job with no ack; the next grant for any requester does a draw only (no erase).

Verification
REQ-028 SHALL verify first draw: after reset, req[0]=1, x=100, y=50, size=8, col=3'b111 -> eng_go one cycle later with (100,50,8,7), no erase; after eng_done, ack[0] pulses once; busy low next cycle.
REQ-029 SHALL verify erase-then-draw: second req[0] with x=104, y=54 -> eng_go (100,50,8,BG_COL), then after eng_done eng_go (104,54,8,7), then ack[0].
REQ-030 SHALL verify round-robin: req=3'b111 held, each ack re-requested -> grant order 0,1,2,0,1,2; with ptr=2 and req=3'b011 -> grant 0 before 1.
REQ-031 SHALL verify size 0: requester 2 with last_valid, size=0 -> one erase eng_go only, ack[2], last_valid[2]=0; next job for 2 does no erase.
REQ-032 SHALL verify stray/held inputs: eng_done pulsed in IDLE -> no state change; x_in changed during DRAW_WAIT -> eng_x unchanged until ack.
REQ-033 SHALL verify reset mid-job: resetn=0 during ERASE_WAIT -> no ack, eng_go=0, busy=0; subsequent req[0] -> draw only, no erase.
